// File: rtl/pool_stage.sv
// 2x2 stride-2 signed average pooling of a raster-order pixel stream.
// Each pooled result is written out through a DMA handshake, one at a time.
module pool_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       size,
  input  logic [15:0]       outAddress,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  output logic              inReady,
  output logic              dmaEnable,
  output logic [15:0]       dmaAddress,
  output logic [DATA_W-1:0] dmaInput,
  input  logic              dmaDone,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LB_DEPTH = MAX_SIZE / 2;
  localparam int unsigned IDX_W    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state_q;
  logic [15:0]              size_q, base_q, row_q, col_q, out_idx_q;
  logic signed [DATA_W:0]   hold_q;
  logic signed [DATA_W:0]   lb_q [LB_DEPTH];
  logic                     dma_en_q, busy_q, done_q, err_q;
  logic [15:0]              dma_addr_q;
  logic [DATA_W-1:0]        dma_data_q;

  logic                     accept, size_ok, last_col, last_row;
  logic signed [DATA_W:0]   pix_ext, pair_d, lb_rd;
  logic signed [DATA_W+1:0] total_d;
  logic [DATA_W-1:0]        avg_d;

  assign inReady    = (state_q == RUN) && !dma_en_q;
  assign accept     = inValid && inReady;
  assign dmaEnable  = dma_en_q;
  assign dmaAddress = dma_addr_q;
  assign dmaInput   = dma_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  assign size_ok  = !size[0] && (size >= 16'd2) && (size <= 16'(MAX_SIZE));
  assign last_col = (col_q == size_q - 16'd1);
  assign last_row = (row_q == size_q - 16'd1);

  // Total is DATA_W+2 bits wide, so the floored quarter always fits DATA_W.
  always_comb begin
    pix_ext = {inData[DATA_W-1], inData};
    pair_d  = hold_q + pix_ext;
    lb_rd   = lb_q[col_q[IDX_W:1]];
    total_d = {lb_rd[DATA_W], lb_rd} + {pair_d[DATA_W], pair_d};
    avg_d   = DATA_W'(total_d >>> 2);
  end

  // Line buffer keeps no reset: every entry is rewritten on an even row first.
  always_ff @(posedge clk) begin
    if (accept && col_q[0] && !row_q[0])
      lb_q[col_q[IDX_W:1]] <= pair_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      size_q     <= '0;
      base_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      out_idx_q  <= '0;
      hold_q     <= '0;
      dma_en_q   <= 1'b0;
      dma_addr_q <= '0;
      dma_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            size_q    <= size;
            base_q    <= outAddress;
            row_q     <= '0;
            col_q     <= '0;
            out_idx_q <= '0;
            busy_q    <= 1'b1;
            if (size_ok) begin
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (dma_en_q && dmaDone) begin
            dma_en_q  <= 1'b0;
            out_idx_q <= out_idx_q + 16'd1;
          end
          if (accept) begin
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + 16'd1;
            end else begin
              col_q <= col_q + 16'd1;
            end
            if (!col_q[0]) begin
              hold_q <= pix_ext;
            end else if (row_q[0]) begin
              dma_en_q   <= 1'b1;
              dma_addr_q <= base_q + out_idx_q;
              dma_data_q <= avg_d;
            end
            if (last_col && last_row)
              state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (dma_en_q && dmaDone) begin
            dma_en_q  <= 1'b0;
            out_idx_q <= out_idx_q + 16'd1;
            state_q   <= DONE;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_stage.sv
// Scoreboard bench for pool_stage: expected writes are derived from the pixel
// map by plain window arithmetic and popped by an independent DMA monitor.
module tb_pool_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] size = '0;
  logic [15:0] outAddress = '0;
  logic        inValid = 1'b0;
  logic [15:0] inData = '0;
  logic        inReady;
  logic        dmaEnable;
  logic [15:0] dmaAddress;
  logic [15:0] dmaInput;
  logic        dmaDone = 1'b0;
  logic        busy, done, err;

  pool_stage #(.DATA_W(16), .MAX_SIZE(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .size(size),
    .outAddress(outAddress), .inValid(inValid), .inData(inData),
    .inReady(inReady), .dmaEnable(dmaEnable), .dmaAddress(dmaAddress),
    .dmaInput(dmaInput), .dmaDone(dmaDone), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  int          pix_q[$];
  int          dma_rand = 0;
  int          stall_cnt = 0;
  int          gap_max = 0;
  int          run_stall = 0;
  int          max_stall = 0;

  // DMA responder: dmaDone toggles regardless of dmaEnable.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0 && dmaEnable) begin
      dmaDone = 1'b0;
      stall_cnt--;
    end else if (dma_rand != 0) begin
      dmaDone = ($urandom_range(0, 2) != 0);
    end else begin
      dmaDone = 1'b1;
    end
  end

  logic        prev_en = 1'b0, prev_dd = 1'b0;
  logic [15:0] prev_addr = '0, prev_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_en   = 1'b0;
      run_stall = 0;
    end else begin
      if (prev_en && !prev_dd) begin
        n_cmp++;
        if (!(dmaEnable && dmaAddress == prev_addr && dmaInput == prev_data)) begin
          n_err++;
          $display("FAIL hold: en=%0b addr=%0d data=%0d required en=1 addr=%0d data=%0d",
                   dmaEnable, dmaAddress, dmaInput, prev_addr, prev_data);
        end
      end
      if (dmaEnable) begin
        n_cmp++;
        if (inReady !== 1'b0) begin
          n_err++;
          $display("FAIL stall_ready: inReady=%0b required 0", inReady);
        end
        run_stall = dmaDone ? 0 : run_stall + 1;
        if (run_stall > max_stall) max_stall = run_stall;
      end
      if (dmaEnable && dmaDone) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL write: unexpected addr=%0d data=%0d, required no write",
                   dmaAddress, $signed(dmaInput));
        end else begin
          logic [31:0] e;
          e = sb_q.pop_front();
          if ({dmaAddress, dmaInput} !== e) begin
            n_err++;
            $display("FAIL write: addr=%0d data=%0d required addr=%0d data=%0d",
                     dmaAddress, $signed(dmaInput), e[31:16], $signed(e[15:0]));
          end
        end
      end
      prev_en   = dmaEnable;
      prev_dd   = dmaDone;
      prev_addr = dmaAddress;
      prev_data = dmaInput;
    end
  end

  function automatic int floor4(input int s);
    int r;
    r = ((s % 4) + 4) % 4;
    return (s - r) / 4;
  endfunction

  task automatic push_expected(input int sz, input int base);
    int h, idx, s, a;
    logic [31:0] v;
    h = sz / 2;
    idx = 0;
    for (int oy = 0; oy < h; oy++)
      for (int ox = 0; ox < h; ox++) begin
        s = pix_q[2*oy*sz + 2*ox] + pix_q[2*oy*sz + 2*ox + 1]
          + pix_q[(2*oy+1)*sz + 2*ox] + pix_q[(2*oy+1)*sz + 2*ox + 1];
        a = floor4(s);
        v[31:16] = 16'((base + idx) % 65536);
        v[15:0]  = 16'(a);
        sb_q.push_back(v);
        idx++;
      end
  endtask

  task automatic start(input int sz, input int base);
    @(posedge clk); #1;
    size = 16'(sz);
    outAddress = 16'(base);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic feed(input int count);
    int budget;
    for (int i = 0; i < count; i++) begin
      if (gap_max > 0)
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      inValid = 1'b1;
      inData  = 16'(pix_q[i]);
      budget  = 0;
      forever begin
        @(negedge clk);
        if (inReady) begin
          @(posedge clk); #1;
          break;
        end
        budget++;
        if (budget > 200) break;
      end
      inValid = 1'b0;
      if (budget > 200) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: pixel %0d never accepted, required acceptance", i);
        return;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    n_cmp++;
    if (k == 5000) begin
      n_err++;
      $display("FAIL %s_done: timeout, required done pulse", name);
    end else if (err !== 1'b0 || busy !== 1'b1 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_done: err=%0b busy=%0b pending=%0d required err=0 busy=1 pending=0",
               name, err, busy, sb_q.size());
    end
  endtask

  task automatic run_map(input string name, input int sz, input int base);
    push_expected(sz, base);
    start(sz, base);
    feed(sz * sz);
    wait_done(name);
  endtask

  task automatic check_illegal(input int sz);
    start(sz, 300);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, err, dmaEnable} !== 4'b1110) begin
      n_err++;
      $display("FAIL illegal_%0d: busy,done,err,dmaEn=%b required 1110", sz, {busy, done, err, dmaEnable});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, err, dmaEnable} !== 4'b0000) begin
      n_err++;
      $display("FAIL illegal_%0d_idle: busy,done,err,dmaEn=%b required 0000", sz, {busy, done, err, dmaEnable});
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({inReady, dmaEnable, busy, done, err} !== 5'b0 || dmaAddress !== 16'd0 || dmaInput !== 16'd0) begin
      n_err++;
      $display("FAIL %s: rdy,en,busy,done,err=%b addr=%0d data=%0d required all 0",
               name, {inReady, dmaEnable, busy, done, err}, dmaAddress, dmaInput);
    end
  endtask

  task automatic ramp(input int n);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(i);
  endtask

  initial begin
    #12;
    check_all_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;

    pix_q = '{1, 2, 3, 4};
    run_map("size2", 2, 100);

    ramp(16);
    run_map("size4", 4, 200);

    pix_q = '{-1, -1, -1, -2};
    run_map("neg_floor", 2, 10);
    pix_q = '{-32768, -32768, -32768, -32768};
    run_map("min_val", 2, 11);
    pix_q = '{32767, 32767, 32767, 32767};
    run_map("max_val", 2, 65535);

    max_stall = 0;
    stall_cnt = 5;
    ramp(16);
    run_map("stall", 4, 400);
    n_cmp++;
    if (max_stall < 5) begin
      n_err++;
      $display("FAIL stall_len: observed %0d held cycles, required >= 5", max_stall);
    end

    check_illegal(5);
    check_illegal(0);
    check_illegal(34);

    ramp(16);
    push_expected(4, 200);
    start(4, 200);
    feed(6);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    run_map("restart", 4, 200);

    dma_rand = 1;
    gap_max = 2;
    for (int m = 0; m < 6; m++) begin
      int sz;
      sz = (m == 0) ? 32 : 2 * $urandom_range(1, 16);
      pix_q.delete();
      for (int i = 0; i < sz * sz; i++) pix_q.push_back(int'($urandom_range(0, 65535)) - 32768);
      run_map("random", sz, int'($urandom_range(0, 65535)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
